seq_trig_capture: RTL



---
 rtl/seq_trig_pkg.sv | 15 +
 rtl/seq_trig_ram.sv | 33 +++
 rtl/seq_trig_capture.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/seq_trig_pkg.sv
// Shared types for the sequence-trigger capture block: FSM state encoding and
// a helper that sizes the stage index.
package seq_trig_pkg;

   typedef enum logic [2:0] {IDLE, ARMED, MATCH, CAPTURE, DONE} state_t;

   // Bits needed to hold a stage index 0..n-1, never less than one.
   function automatic int idx_w(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) w = w + 1;
      return w;
   endfunction

endpackage

// File: rtl/seq_trig_ram.sv
// Simple dual-port capture buffer: one write port, one registered read port.
// A same-address read and write in one cycle returns the previous contents.
module seq_trig_ram #(
   parameter int DATA_W = 8,
   parameter int AW     = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [AW-1:0]     raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [2**AW];
   logic [DATA_W-1:0] rd_data_d;
   logic [DATA_W-1:0] rd_data_q;

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   always_comb rd_data_d = mem[raddr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rd_data_q <= '0;
      else        rd_data_q <= rd_data_d;
   end

   assign rdata = rd_data_q;

endmodule

// File: rtl/seq_trig_capture.sv
// Armed multi-stage trigger followed by a DEPTH-sample capture into a buffer.
// Define SEQ_TRIG_MASK_EN to add the per-stage don't-care mask input trig_mask.
module seq_trig_capture
   import seq_trig_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int TRIG_W  = 2,
   parameter int SEQ_LEN = 3,
   parameter int DEPTH   = 42,
   parameter int AW      = 6,
   parameter int DIV_W   = 32
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      arm,
   input  logic                      abort,
   input  logic [DIV_W-1:0]          div,
   input  logic [SEQ_LEN*TRIG_W-1:0] trig_pattern,
`ifdef SEQ_TRIG_MASK_EN
   input  logic [SEQ_LEN*TRIG_W-1:0] trig_mask,
`endif
   input  logic [TRIG_W-1:0]         trig_data,
   input  logic [DATA_W-1:0]         din,
   input  logic [AW-1:0]             rd_addr,
   output logic [DATA_W-1:0]         rd_data,
   output logic                      busy,
   output logic                      triggered,
   output logic                      done,
   output logic [AW:0]               wr_count
);

   localparam int            SW         = idx_w(SEQ_LEN);
   localparam logic [SW-1:0] LAST_STAGE = SW'(SEQ_LEN - 1);
   localparam logic [AW:0]   LAST_ADDR  = (AW + 1)'(DEPTH - 1);

   state_t              state_q, state_d;
   logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
   logic [TRIG_W-1:0]   trig_q, trig_d;
   logic [DATA_W-1:0]   din_q, din_d;
   logic [SW-1:0]       stage_q, stage_d;
   logic [AW:0]         wr_count_q, wr_count_d;
   logic                done_q, done_d;
   logic                triggered_q, triggered_d;

   logic                tick, arm_ok, stage_hit, final_hit, wr_en, busy_c;
   logic [TRIG_W-1:0]   stage_pat, stage_msk;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Abort overrides everything, including an arm in the same cycle.
   always_comb begin
      state_d = state_q;
      if (abort) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE, DONE: if (arm) state_d = ARMED;
            ARMED:      if (tick && stage_hit) state_d = (SEQ_LEN == 1) ? CAPTURE : MATCH;
            MATCH: begin
               if (tick) begin
                  if (!stage_hit)                 state_d = ARMED;
                  else if (stage_q == LAST_STAGE) state_d = CAPTURE;
               end
            end
            CAPTURE:    if (wr_en && wr_count_q == LAST_ADDR) state_d = DONE;
            default:    state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      busy_c    = (state_q == ARMED) || (state_q == MATCH) || (state_q == CAPTURE);
      final_hit = tick && stage_hit &&
                  (((state_q == ARMED) && (SEQ_LEN == 1)) ||
                   ((state_q == MATCH) && (stage_q == LAST_STAGE)));
      wr_en     = !abort && (final_hit || ((state_q == CAPTURE) && tick));
   end

   always_comb begin
      stage_pat = '0;
      stage_msk = '0;
      for (int k = 0; k < SEQ_LEN; k++) begin
         if (stage_q == SW'(k)) begin
            stage_pat = trig_pattern[(SEQ_LEN-1-k)*TRIG_W +: TRIG_W];
`ifdef SEQ_TRIG_MASK_EN
            stage_msk = trig_mask[(SEQ_LEN-1-k)*TRIG_W +: TRIG_W];
`endif
         end
      end
      stage_hit = ((trig_q ^ stage_pat) & ~stage_msk) == '0;
   end

   always_comb begin
      arm_ok      = arm && !abort && ((state_q == IDLE) || (state_q == DONE));
      tick        = (div_cnt_q == div);
      div_cnt_d   = (arm_ok || tick) ? '0 : div_cnt_q + 1'b1;
      trig_d      = trig_data;
      din_d       = din;

      stage_d     = stage_q;
      wr_count_d  = wr_count_q;
      done_d      = done_q;
      triggered_d = triggered_q;
      if (abort || arm_ok) begin
         stage_d     = '0;
         done_d      = 1'b0;
         triggered_d = 1'b0;
         if (arm_ok) wr_count_d = '0;
      end else begin
         if (tick && ((state_q == ARMED) || (state_q == MATCH)))
            stage_d = (stage_hit && !final_hit) ? stage_q + 1'b1 : '0;
         if (wr_en) wr_count_d = wr_count_q + 1'b1;
         if (final_hit) triggered_d = 1'b1;
         if (wr_en && wr_count_q == LAST_ADDR) done_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt_q   <= '0;
         trig_q      <= '0;
         din_q       <= '0;
         stage_q     <= '0;
         wr_count_q  <= '0;
         done_q      <= 1'b0;
         triggered_q <= 1'b0;
      end else begin
         div_cnt_q   <= div_cnt_d;
         trig_q      <= trig_d;
         din_q       <= din_d;
         stage_q     <= stage_d;
         wr_count_q  <= wr_count_d;
         done_q      <= done_d;
         triggered_q <= triggered_d;
      end
   end

   // Write address is the running write count, so capture always starts at 0.
   seq_trig_ram #(.DATA_W(DATA_W), .AW(AW)) u_ram (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (wr_en),
      .waddr (wr_count_q[AW-1:0]),
      .wdata (din_q),
      .raddr (rd_addr),
      .rdata (rd_data)
   );

   assign busy      = busy_c;
   assign triggered = triggered_q;
   assign done      = done_q;
   assign wr_count  = wr_count_q;

endmodule
